// File: rtl/wb_stage_buf.sv
// wb_stage_buf: write-back stage buffer with in-order retirement, forwarding lookup and retire counter
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allow,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [PC_W-1:0]           in_inst,
  input  logic                      in_we,
  input  logic [REG_AW-1:0]         in_dest,
  input  logic [DATA_W-1:0]         in_result,
  input  logic                      flush,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [REG_AW-1:0]         qry_addr,
  output logic                      qry_hit,
  output logic [DATA_W-1:0]         qry_data,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [31:0]               retire_cnt,
  output logic [PC_W-1:0]           debug_wb_pc,
  output logic [3:0]                debug_wb_rf_we,
  output logic [REG_AW-1:0]         debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [PC_W-1:0]   r_inst [DEPTH];
  logic [REG_AW-1:0] r_dest [DEPTH];
  logic [DATA_W-1:0] r_res  [DEPTH];
  logic [DEPTH-1:0]  r_we;
  logic [DEPTH-1:0]  r_vld;
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_ret;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  logic [DATA_W-1:0] w_qd;
  logic [AW-1:0]     w_idx;
  logic              w_unused_inst;

  // Full/empty come from registered occupancy only, so in_allow never depends on rf_ready.
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_push   = in_valid & ~w_full & ~flush;
  assign w_pop    = ~w_empty & rf_ready & ~flush;
  assign in_allow = ~w_full;

  assign rf_we             = w_pop & r_we[r_rp];
  assign rf_waddr          = w_empty ? '0 : r_dest[r_rp];
  assign rf_wdata          = w_empty ? '0 : r_res[r_rp];
  assign debug_wb_pc       = w_empty ? '0 : r_pc[r_rp];
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign occupancy         = r_cnt;
  assign retire_cnt        = r_ret;
  assign qry_hit           = w_hit;
  assign qry_data          = w_qd;

  // The instruction word is carried for completeness but nothing downstream consumes it.
  assign w_unused_inst = ^r_inst[r_rp];

  // Pointer, occupancy, valid and retire bookkeeping; flush empties the buffer without retiring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
      r_ret <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push) r_vld[r_wp] <= 1'b1;
      if (w_pop) r_vld[r_rp] <= 1'b0;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ret <= r_ret + 32'(w_pop);
    end
  end

  // Payload capture; a write to x0 is stored as a non-writing entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wp]   <= in_pc;
      r_inst[r_wp] <= in_inst;
      r_we[r_wp]   <= in_we & (in_dest != '0);
      r_dest[r_wp] <= in_dest;
      r_res[r_wp]  <= in_result;
    end
  end

  // Forwarding lookup scans oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_hit = 1'b0;
    w_qd  = '0;
    w_idx = r_rp;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rp + AW'(i);
      if (r_vld[w_idx] && r_we[w_idx] && (r_dest[w_idx] == qry_addr) && (qry_addr != '0)) begin
        w_hit = 1'b1;
        w_qd  = r_res[w_idx];
      end
    end
  end
endmodule

// File: doc/wb_stage_buf.md
WB_STAGE_BUF -- requirements
Module: wb_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result/write-data width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have parameter PC_W, default 32, meaning PC and instruction width.
REQ-004 SHALL have parameter DEPTH, default 2, meaning buffer entries; legal values are powers of 2 that are 2 or greater.
REQ-005 SHALL have ports as follows:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- in_valid  in  1  MEM presents an instruction.
- in_allow  out  1  stage accepts; equals ~full.
- in_pc, in_inst  in  PC_W each  instruction PC and word.
- in_we  in  1  instruction writes a GPR.
- in_dest  in  REG_AW  destination register.
- in_result  in  DATA_W  final result.
- flush  in  1  discard buffer and the same-cycle input.
- rf_ready  in  1  register-file write port available this cycle.
- rf_we  out  1  write strobe.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- qry_addr  in  REG_AW  forwarding lookup address.
- qry_hit  out  1  pending write to qry_addr exists.
- qry_data  out  DATA_W  youngest pending data for qry_addr.
- occupancy  out  clog2(DEPTH)+1  valid entry count.
- retire_cnt  out  32  retired-instruction counter.
- debug_wb_pc  out  PC_W  head PC.
- debug_wb_rf_we  out  4  replicated commit strobe.
- debug_wb_rf_wnum  out  REG_AW  commit register.
- debug_wb_rf_wdata  out  DATA_W  commit data.

Function
REQ-006 SHALL implement a DEPTH-entry circular FIFO of {pc, inst, we, dest, result} with registered read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-007 SHALL push the input when in_valid & in_allow & ~flush, storing we as in_we & (in_dest != 0).
REQ-008 SHALL drive in_allow = ~full using registered state only, with no same-cycle pop bypass; a full buffer popping this cycle still deasserts in_allow.
REQ-009 SHALL pop the head when ~empty & rf_ready & ~flush; a pop is one retirement.
REQ-010 SHALL drive rf_we = ~empty & head.we & rf_ready & ~flush, with rf_waddr = head.dest and rf_wdata = head.result.
REQ-011 SHALL give each entry one-cycle minimum residency: an entry pushed at edge N is eligible to write at cycle N+1 or later.
REQ-012 SHALL, when push and pop occur in the same cycle, leave occupancy unchanged and advance both pointers.
REQ-013 SHALL, on flush, invalidate all entries, zero both pointers and occupancy at the next edge, and suppress the same-cycle write and push; retire_cnt does not increment.
REQ-014 SHALL set qry_hit = 1 iff qry_addr != 0 and some valid entry has we=1 and dest == qry_addr.
REQ-015 SHALL set qry_data to the result of the youngest such entry, or 0 on a miss; qry_hit and qry_data are combinational.
REQ-016 SHALL increment retire_cnt by 1 per pop, including we=0 entries, wrapping from 0xFFFFFFFF to 0.
REQ-017 SHALL drive debug_wb_pc = head.pc (0 when empty), debug_wb_rf_we = {4{rf_we}}, debug_wb_rf_wnum = rf_waddr and debug_wb_rf_wdata = rf_wdata.
REQ-018 SHALL drive rf_waddr, rf_wdata and debug outputs to 0 when empty.

Reset
REQ-019 SHALL, on reset assertion, immediately clear pointers, occupancy, all entry valid bits and retire_cnt, independent of clk.
REQ-020 SHALL, while reset is asserted, drive in_allow=1, rf_we=0, qry_hit=0, occupancy=0 and all data/debug outputs 0.
REQ-021 SHALL lose any entries held when reset asserts mid-operation, and accept a push at the first edge after deassertion.

Verification
REQ-022 SHALL pass this test: with rf_ready=1, push pc=0x1C000000, we=1, dest=5, result=0xDEADBEEF -> the next cycle gives rf_we=1, waddr=5, wdata=0xDEADBEEF, debug_wb_rf_we=0xF, and retire_cnt goes 0->1.
REQ-023 SHALL pass this test: with rf_ready=0, push 3 instructions at DEPTH=2 -> the first two are accepted, in_allow=0 with occupancy=2, the third is held by MEM; then rf_ready=1 -> writes retire in order, one per cycle.
REQ-024 SHALL pass this test: buffer holds dest=7/0x11 (older) and dest=7/0x22 (younger), qry_addr=7 -> qry_hit=1, qry_data=0x22; qry_addr=0 -> qry_hit=0.
REQ-025 SHALL pass this test: push dest=0, we=1 -> the entry retires with rf_we=0 and retire_cnt increments.
REQ-026 SHALL pass this test: with occupancy=2 and rf_ready=1, assert flush alongside in_valid=1 -> rf_we=0 that cycle, occupancy=0 next cycle, and retire_cnt is unchanged.
REQ-027 SHALL pass this test: assert reset asynchronously between edges with occupancy=1 -> occupancy=0 and rf_we=0 before the next edge.
